// File: rtl/exception_issue_unit_if.sv
// MEM-stage exception/interrupt bus between the pipeline and the exception issue unit.
// The master drives instruction and interrupt state; the slave returns abort strobes and captured cause.
interface exception_issue_unit_if #(
    parameter int IRQ_W = 6
);
    logic             mem_valid;
    logic [31:0]      mem_instr;
    logic [4:0]       mem_exc_code;
    logic [IRQ_W-1:0] irq_in;
    logic [IRQ_W-1:0] irq_mask;
    logic             int_enable;
    logic             eret;

    logic             exception_abort;
    logic             r_p;
    logic             r_h;
    logic             irq;
    logic [31:0]      badvinstr_p;
    logic [4:0]       exc_code_o;
    logic             flush;
    logic             in_handler;

    modport master (
        output mem_valid, mem_instr, mem_exc_code, irq_in, irq_mask, int_enable, eret,
        input  exception_abort, r_p, r_h, irq, badvinstr_p, exc_code_o, flush, in_handler
    );

    modport slave (
        input  mem_valid, mem_instr, mem_exc_code, irq_in, irq_mask, int_enable, eret,
        output exception_abort, r_p, r_h, irq, badvinstr_p, exc_code_o, flush, in_handler
    );
endinterface

// File: rtl/exception_issue_unit.sv
// Prioritises MEM-stage precise exceptions over masked interrupts and sequences abort/handler/return.
// Define EXC_IRQ_SYNC_EN to pass irq_in through a 2-flop synchronizer before masking.
//
// state   | meaning
// IDLE    | watching MEM stage for an exception or pending interrupt
// ABORT   | one-cycle abort/flush strobe, cause captured
// HANDLER | handler running, further events blocked until eret
// RETURN  | one-cycle exit from handler back to IDLE
module exception_issue_unit #(
    parameter int IRQ_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    exception_issue_unit_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ABORT   = 2'd1,
        HANDLER = 2'd2,
        RETURN  = 2'd3
    } state_t;

    state_t           state;
    state_t           nxt_state;
    logic [IRQ_W-1:0] irq_s;
    logic             exc_hit;
    logic             irq_hit;
    logic             take_exc;
    logic             take_irq;

`ifdef EXC_IRQ_SYNC_EN
    logic [IRQ_W-1:0] sync_1;
    logic [IRQ_W-1:0] sync_2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= bus.irq_in;
            sync_2 <= sync_1;
        end
    end

    assign irq_s = sync_2;
`else
    assign irq_s = bus.irq_in;
`endif

    // Mask after synchronization so irq_mask changes act immediately.
    assign exc_hit = bus.mem_valid && (bus.mem_exc_code != 5'd0);
    assign irq_hit = bus.mem_valid && bus.int_enable && (|(irq_s & bus.irq_mask));

    always_comb begin
        nxt_state = state;
        take_exc  = 1'b0;
        take_irq  = 1'b0;
        case (state)
            IDLE: begin
                if (exc_hit) begin
                    take_exc  = 1'b1;
                    nxt_state = ABORT;
                end else if (irq_hit) begin
                    take_irq  = 1'b1;
                    nxt_state = ABORT;
                end
            end
            ABORT:   nxt_state = HANDLER;
            HANDLER: if (bus.eret) nxt_state = RETURN;
            RETURN:  nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.exception_abort <= 1'b0;
            bus.r_p             <= 1'b0;
            bus.r_h             <= 1'b0;
            bus.irq             <= 1'b0;
            bus.flush           <= 1'b0;
            bus.in_handler      <= 1'b0;
            bus.badvinstr_p     <= 32'h0;
            bus.exc_code_o      <= 5'd0;
        end else begin
            bus.exception_abort <= take_exc | take_irq;
            bus.r_p             <= take_exc;
            bus.r_h             <= take_irq;
            bus.irq             <= take_irq;
            bus.flush           <= take_exc | take_irq;
            bus.in_handler      <= (nxt_state == HANDLER);
            if (take_exc) begin
                bus.badvinstr_p <= bus.mem_instr;
                bus.exc_code_o  <= bus.mem_exc_code;
            end else if (take_irq) begin
                bus.badvinstr_p <= bus.mem_instr;
                bus.exc_code_o  <= 5'd0;
            end
        end
    end
endmodule

// File: doc/exception_issue_unit.md
EXCEPTION_ISSUE_UNIT -- requirements
Module: exception_issue_unit

Interface
REQ-001 Parameter IRQ_W, default 6, number of external interrupt lines.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 mem_valid  input  1  MEM-stage instruction valid.
REQ-005 mem_instr  input  32  MEM-stage instruction word.
REQ-006 mem_exc_code  input  5  synchronous exception code of MEM instruction; 0 = none.
REQ-007 irq_in  input  IRQ_W  raw external interrupt lines, level, asynchronous.
REQ-008 irq_mask  input  IRQ_W  per-line interrupt enable.
REQ-009 int_enable  input  1  global interrupt enable.
REQ-010 eret  input  1  exception-return retiring in MEM.
REQ-011 exception_abort  output  1  one-cycle abort strobe to CP0 units.
REQ-012 r_p  output  1  capture strobe: precise (synchronous) exception.
REQ-013 r_h  output  1  capture strobe: interrupt (hardware) event.
REQ-014 irq  output  1  interrupt-cause flag, valid with exception_abort.
REQ-015 badvinstr_p  output  32  faulting/interrupted instruction word.
REQ-016 exc_code_o  output  5  cause code issued.
REQ-017 flush  output  1  pipeline flush, coincident with exception_abort.
REQ-018 in_handler  output  1  handler active (EXL-equivalent).

Function
REQ-019 FSM states IDLE, ABORT, HANDLER, RETURN; all outputs registered.
REQ-020 IDLE: mem_valid=1 and mem_exc_code!=0 at edge N -> ABORT at N+1; exception_abort=1, r_p=1, r_h=0, irq=0, flush=1, exc_code_o=mem_exc_code, badvinstr_p=mem_instr.
REQ-021 IDLE: mem_valid=1, mem_exc_code=0, int_enable=1, |(irq_s & irq_mask)!=0 -> ABORT at N+1; exception_abort=1, r_h=1, irq=1, r_p=0, flush=1, exc_code_o=0, badvinstr_p=mem_instr.
REQ-022 Simultaneous exception and pending interrupt: exception wins (REQ-020); interrupt stays pending.
REQ-023 mem_valid=0: exceptions and interrupts not taken; no strobe.
REQ-024 ABORT lasts exactly one cycle, then HANDLER; exception_abort, r_p, r_h, irq, flush low outside ABORT.
REQ-025 HANDLER: in_handler=1; new exceptions/interrupts ignored (no strobe, no capture); eret=1 -> RETURN.
REQ-026 RETURN lasts one cycle, in_handler=0, then IDLE; next event takeable from IDLE the following cycle.
REQ-027 eret in IDLE, ABORT or RETURN ignored.
REQ-028 badvinstr_p and exc_code_o hold last captured values until next ABORT.
REQ-029 irq_s = synchronized irq_in per Configuration; masking applied after synchronization.

Reset
REQ-030 rst=0 asynchronously forces IDLE; all outputs 0, badvinstr_p=32'h0, synchronizer flops 0.
REQ-031 Reset mid-ABORT or mid-HANDLER aborts the sequence; no strobe issued after rst release until a new event.
REQ-032 First event takeable at the first rising edge after rst deasserts (plus synchronizer latency).

Configuration
REQ-033 Macro EXC_IRQ_SYNC_EN defined: irq_in passes a 2-flop synchronizer; irq_s lags irq_in by 2 cycles.
REQ-034 EXC_IRQ_SYNC_EN undefined: irq_s = irq_in combinationally; zero added latency; exception path unchanged.

Verification
REQ-035 Reset: rst=0 with irq_in=all 1s -> all outputs 0, state IDLE; hold 3 cycles, no strobe.
REQ-036 Precise: mem_valid=1, mem_exc_code=5'h0A, mem_instr=32'h0000_000F -> next cycle exception_abort=1, r_p=1, r_h=0, badvinstr_p=32'h0000_000F, exc_code_o=5'h0A; then in_handler=1.
REQ-037 Interrupt: irq_mask=6'h01, int_enable=1, irq_in=6'h01, mem_instr=32'h0000_00FF -> abort with r_h=1, irq=1, exc_code_o=0, badvinstr_p=32'h0000_00FF; latency 3 cycles with EXC_IRQ_SYNC_EN, 1 without.
REQ-038 Collision: exc_code=5'h04 and unmasked irq same cycle -> r_p=1, r_h=0, exc_code_o=5'h04; after eret+RETURN, interrupt taken with r_h=1.
REQ-039 Handler blocking: in HANDLER apply exc_code=5'h08 for 4 cycles -> no strobe, badvinstr_p unchanged; eret -> RETURN one cycle -> IDLE.
REQ-040 Reset mid-HANDLER: rst=0 for one cycle -> in_handler=0, badvinstr_p=0 asynchronously; masked irq_in=6'h02 with irq_mask=6'h01 -> no abort.
